suma_pf_secuencial: RTL and testbench

//  Parametrised multi-cycle IEEE-754 style floating-point adder/subtractor with valid/ready handshake.

---
 rtl/suma_pf_secuencial_pkg.sv | 30 +++
 rtl/suma_pf_secuencial_lzc.sv | 30 +++
 rtl/suma_pf_secuencial.sv | 236 +++++++++++++++++++++++
 tb/tb_suma_pf_secuencial.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/suma_pf_secuencial_pkg.sv
// ----------------------------------------------------------------------------
// suma_pf_secuencial_pkg : FSM states, flag bit positions and rounding helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package suma_pf_secuencial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Round-to-nearest-even increment decision from lsb and guard/round/sticky.
  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/suma_pf_secuencial_lzc.sv
// ----------------------------------------------------------------------------
// suma_pf_secuencial_lzc : combinational leading-zero counter (all-zero -> N)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module suma_pf_secuencial_lzc #(
  parameter int N  = 27,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  logic found;

  always_comb begin
    cnt_o = CW'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && vec_i[i]) begin
        cnt_o = CW'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/suma_pf_secuencial.sv
// ----------------------------------------------------------------------------
// suma_pf_secuencial : multi-cycle IEEE-754 style FP add/sub, RNE, status flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module suma_pf_secuencial
  import suma_pf_secuencial_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam int LW = $clog2(MW + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

  state_t state_q, state_d;

  logic                 sa_q, sb_q, sgn_q, sub_q, spec_q, zero_q, uf_q;
  logic [EXP_W-1:0]     ea_q, eb_q;
  logic [MAN_W:0]       ma_q, mb_q;
  logic [W-1:0]         spec_res_q, result_q;
  logic [3:0]           spec_flg_q, flags_q;
  logic signed [EW-1:0] exp_q;
  logic [MW-1:0]        mbig_q, msml_q, nm_q;
  logic [SW-1:0]        sum_q;

  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_sb, w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic             w_spec;
  logic [W-1:0]     w_spec_res;
  logic [3:0]       w_spec_flg;

  assign w_ea     = a[W-2:MAN_W];
  assign w_eb     = b[W-2:MAN_W];
  assign w_fa     = a[MAN_W-1:0];
  assign w_fb     = b[MAN_W-1:0];
  assign w_sb     = b[W-1] ^ op_sub;
  assign w_a_max  = &w_ea;
  assign w_b_max  = &w_eb;
  assign w_a_nan  = w_a_max & (|w_fa);
  assign w_b_nan  = w_b_max & (|w_fb);
  assign w_a_inf  = w_a_max & ~(|w_fa);
  assign w_b_inf  = w_b_max & ~(|w_fb);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = QNAN;
    w_spec_flg = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[W-1] != w_sb))) begin
      w_spec_flg[FLAG_INVALID] = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Alignment: order operands by magnitude, shift the smaller one into GRS.
  logic             w_swap, w_sbig;
  logic [EXP_W-1:0] w_ebig, w_esml;
  logic [MAN_W:0]   w_mbig, w_msml;
  logic [EW-1:0]    w_diff;
  logic [MW-1:0]    w_xs, w_sh, w_al;

  always_comb begin
    w_swap = {eb_q, mb_q} > {ea_q, ma_q};
    w_sbig = w_swap ? sb_q : sa_q;
    w_ebig = w_swap ? eb_q : ea_q;
    w_esml = w_swap ? ea_q : eb_q;
    w_mbig = w_swap ? mb_q : ma_q;
    w_msml = w_swap ? ma_q : mb_q;
    w_diff = {2'b00, w_ebig} - {2'b00, w_esml};
    w_xs   = {w_msml, 3'b000};
    w_sh   = w_xs >> w_diff;
    if (w_diff >= EW'(MAN_W + 3)) begin
      w_al = {{(MW-1){1'b0}}, |w_xs};
    end else begin
      w_al = {w_sh[MW-1:1], w_sh[0] | (|(w_xs & ~({MW{1'b1}} << w_diff)))};
    end
  end

  logic [LW-1:0]        w_lz;
  logic [MW-1:0]        w_nl;
  logic signed [EW-1:0] w_ne;

  suma_pf_secuencial_lzc #(.N(MW), .CW(LW)) u_lzc (
    .vec_i (sum_q[MW-1:0]),
    .cnt_o (w_lz)
  );

  assign w_nl = sum_q[MW-1:0] << w_lz;
  assign w_ne = exp_q - $signed(EW'(w_lz));

  logic                 w_inc;
  logic [MAN_W+1:0]     w_rm;
  logic signed [EW-1:0] w_re;
  logic [W-1:0]         w_res;
  logic [3:0]           w_flg;

  always_comb begin
    w_inc = rne_inc(nm_q[3], nm_q[2], nm_q[1], nm_q[0]);
    w_rm  = {1'b0, nm_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    w_re  = w_rm[MAN_W+1] ? exp_q + EW'(1) : exp_q;
    // On a rounding carry the low mantissa bits are already zero (1.000...).
    w_res = {sgn_q, w_re[EXP_W-1:0], w_rm[MAN_W-1:0]};
    w_flg = '0;
    if (spec_q) begin
      w_res = spec_res_q;
      w_flg = spec_flg_q;
    end else if (zero_q) begin
      w_res                 = {sgn_q, {(EXP_W+MAN_W){1'b0}}};
      w_flg[FLAG_UNDERFLOW] = uf_q;
    end else if (w_re >= E_MAX) begin
      w_res                = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flg[FLAG_OVERFLOW] = 1'b1;
      w_flg[FLAG_INEXACT]  = 1'b1;
    end else begin
      w_flg[FLAG_INEXACT] = |nm_q[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ALIGN;
      end
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q <= 1'b0; sb_q <= 1'b0; sgn_q <= 1'b0; sub_q <= 1'b0;
      spec_q <= 1'b0; zero_q <= 1'b0; uf_q <= 1'b0;
      ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      spec_res_q <= '0; spec_flg_q <= '0; result_q <= '0; flags_q <= '0;
      exp_q <= '0; mbig_q <= '0; msml_q <= '0; nm_q <= '0; sum_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sa_q       <= a[W-1];
          sb_q       <= w_sb;
          ea_q       <= w_a_zero ? '0 : w_ea;
          eb_q       <= w_b_zero ? '0 : w_eb;
          ma_q       <= w_a_zero ? '0 : {1'b1, w_fa};
          mb_q       <= w_b_zero ? '0 : {1'b1, w_fb};
          spec_q     <= w_spec;
          spec_res_q <= w_spec_res;
          spec_flg_q <= w_spec_flg;
        end
        ALIGN: begin
          sgn_q  <= w_sbig;
          sub_q  <= sa_q ^ sb_q;
          exp_q  <= $signed({2'b00, w_ebig});
          mbig_q <= {w_mbig, 3'b000};
          msml_q <= w_al;
        end
        ADD: sum_q <= sub_q ? ({1'b0, mbig_q} - {1'b0, msml_q}) : ({1'b0, mbig_q} + {1'b0, msml_q});
        NORM: begin
          if (sum_q[SW-1]) begin
            nm_q   <= {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            exp_q  <= exp_q + EW'(1);
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
          end else if (sum_q == '0) begin
            // Exact cancellation gives +0; only like-signed zeros keep their sign.
            nm_q   <= '0;
            zero_q <= 1'b1;
            uf_q   <= 1'b0;
            sgn_q  <= sub_q ? 1'b0 : sgn_q;
          end else if (w_ne <= 0) begin
            nm_q   <= '0;
            zero_q <= 1'b1;
            uf_q   <= 1'b1;
          end else begin
            nm_q   <= w_nl;
            exp_q  <= w_ne;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
          end
        end
        ROUND: begin
          result_q <= w_res;
          flags_q  <= w_flg;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_suma_pf_secuencial.sv
// ----------------------------------------------------------------------------
// tb_suma_pf_secuencial : directed vectors, expected-result queue, monitor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_suma_pf_secuencial;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [35:0] exp_q[$];
  int          acc_q[$];
  logic        prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  suma_pf_secuencial #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency from acceptance and in-order result/flags comparison.
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL latency: out_valid rose with no accepted operation");
        end else begin
          int t;
          t = acc_q.pop_front();
          check("latency", 64'(cyc - t), 64'd5);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: result 0x%0h retired with nothing expected", result);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e[31:0]));
          check("flags",  64'(flags),  64'(e[35:32]));
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                      input logic [31:0] er, input logic [3:0] ef);
    int n;
    @(posedge clk); #1;
    a = va; b = vb; op_sub = vop; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end else begin
      exp_q.push_back({ef, er});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((!in_ready || exp_q.size() != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("idle_reached", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n, hits;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_flags",     64'(flags),     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0); // 1+2
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0); // 1-1
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0); // -0 + -0
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5); // overflow
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1); // tie to even, down
    send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1); // above half
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1); // tie to even, up
    send(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'h1); // rounding carry
    send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8); // inf - inf
    send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8); // NaN
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0); // inf + finite
    send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0); // 3-1
    send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0); // 1-2
    send(32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'h0); // denormal flushed
    send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h2); // underflow flush

    // Backpressure: hold DONE for 10 cycles.
    wait_idle();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", {27'd0, out_valid, in_ready, flags, result}, {27'd0, 1'b1, 1'b0, 4'h0, 32'h40400000});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset while the operation sits in ADD: nothing may be emitted.
    wait_idle();
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("abort_no_output", 64'(hits), 64'd0);
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
